// File: rtl/data_fifo_param_if.sv
// Producer/consumer bundle for data_fifo_param: push/pop controls in, data and status out.
interface data_fifo_param_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic                  write_enable;
  logic [DATA_WIDTH-1:0] write_data;
  logic                  fifo_request_data;
  logic                  flush;
  logic                  clear_flags;
  logic [DATA_WIDTH-1:0] fifo_data;
  logic                  fifo_data_valid;
  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  fifo_almost_empty;
  logic                  fifo_almost_full;
  logic [CW-1:0]         fifo_count;
  logic                  fifo_overflow;
  logic                  fifo_underflow;

  modport master (
    output write_enable, write_data, fifo_request_data, flush, clear_flags,
    input  fifo_data, fifo_data_valid, fifo_empty, fifo_full, fifo_almost_empty,
           fifo_almost_full, fifo_count, fifo_overflow, fifo_underflow
  );

  modport slave (
    input  write_enable, write_data, fifo_request_data, flush, clear_flags,
    output fifo_data, fifo_data_valid, fifo_empty, fifo_full, fifo_almost_empty,
           fifo_almost_full, fifo_count, fifo_overflow, fifo_underflow
  );
endinterface

// File: rtl/data_fifo_param.sv
// Parametrised synchronous FIFO with registered read data, occupancy count,
// almost-full/empty thresholds, sticky overflow/underflow flags and flush.
module data_fifo_param #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_LEVEL   = DEPTH - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  data_fifo_param_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);

  generate
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (AF_LEVEL > DEPTH) || (AE_LEVEL >= DEPTH)) begin : g_param_err
      $error("data_fifo_param: illegal DEPTH/AF_LEVEL/AE_LEVEL combination");
    end
  endgenerate

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]         wr_ptr_r;
  logic [AW-1:0]         rd_ptr_r;
  logic [CW-1:0]         count_r;
  logic [CW-1:0]         count_nxt_s;
  logic [DATA_WIDTH-1:0] rd_data_r;
  logic                  rd_valid_r;
  logic                  ovf_r;
  logic                  udf_r;
  logic                  ovf_nxt_s;
  logic                  udf_nxt_s;
  logic                  empty_s;
  logic                  full_s;
  logic                  rd_accept_s;
  logic                  wr_accept_s;
  logic                  ovf_event_s;
  logic                  udf_event_s;

  assign empty_s = (count_r == {CW{1'b0}});
  assign full_s  = (count_r == DEPTH_C);

  assign bus.fifo_empty        = empty_s;
  assign bus.fifo_full         = full_s;
  assign bus.fifo_almost_empty = (count_r <= AE_C);
  assign bus.fifo_almost_full  = (count_r >= AF_C);
  assign bus.fifo_count        = count_r;
  assign bus.fifo_data         = rd_data_r;
  assign bus.fifo_data_valid   = rd_valid_r;
  assign bus.fifo_overflow     = ovf_r;
  assign bus.fifo_underflow    = udf_r;

  // Accept/event decode; flush masks both directions and suppresses flag events.
  always_comb begin
    rd_accept_s = 1'b0;
    wr_accept_s = 1'b0;
    ovf_event_s = 1'b0;
    udf_event_s = 1'b0;
    if (bus.flush) begin
      rd_accept_s = 1'b0;
      wr_accept_s = 1'b0;
    end else begin
      rd_accept_s = bus.fifo_request_data && !empty_s;
      // A read in the same cycle frees a slot, so a full FIFO still takes the write.
      wr_accept_s = bus.write_enable && (!full_s || rd_accept_s);
      ovf_event_s = bus.write_enable && !wr_accept_s;
      udf_event_s = bus.fifo_request_data && empty_s;
    end
  end

  // Next occupancy and sticky flag values; a new event beats clear_flags.
  always_comb begin
    count_nxt_s = count_r;
    if (bus.flush) begin
      count_nxt_s = {CW{1'b0}};
    end else begin
      case ({wr_accept_s, rd_accept_s})
        2'b10:   count_nxt_s = count_r + CW'(1);
        2'b01:   count_nxt_s = count_r - CW'(1);
        default: count_nxt_s = count_r;
      endcase
    end
    ovf_nxt_s = ovf_event_s ? 1'b1 : (bus.clear_flags ? 1'b0 : ovf_r);
    udf_nxt_s = udf_event_s ? 1'b1 : (bus.clear_flags ? 1'b0 : udf_r);
  end

  // Pointer, count, read-data and flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r   <= {AW{1'b0}};
      rd_ptr_r   <= {AW{1'b0}};
      count_r    <= {CW{1'b0}};
      rd_data_r  <= {DATA_WIDTH{1'b0}};
      rd_valid_r <= 1'b0;
      ovf_r      <= 1'b0;
      udf_r      <= 1'b0;
    end else begin
      count_r    <= count_nxt_s;
      rd_valid_r <= rd_accept_s;
      ovf_r      <= ovf_nxt_s;
      udf_r      <= udf_nxt_s;
      if (bus.flush) begin
        wr_ptr_r <= {AW{1'b0}};
        rd_ptr_r <= {AW{1'b0}};
      end else begin
        if (wr_accept_s) begin
          wr_ptr_r <= wr_ptr_r + AW'(1);
        end
        if (rd_accept_s) begin
          rd_ptr_r  <= rd_ptr_r + AW'(1);
          rd_data_r <= mem_r[rd_ptr_r];
        end
      end
    end
  end

  // Storage array; contents are deliberately left unreset.
  always_ff @(posedge clk) begin
    if (wr_accept_s) begin
      mem_r[wr_ptr_r] <= bus.write_data;
    end
  end
endmodule

// File: tb/tb_data_fifo_param.sv
// Scoreboard bench for data_fifo_param at DEPTH=8, DATA_WIDTH=8, AF_LEVEL=6, AE_LEVEL=2.
module tb_data_fifo_param;
  localparam int DW    = 8;
  localparam int DEPTH = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  data_fifo_param_if #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) bus ();

  data_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .AF_LEVEL(6), .AE_LEVEL(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] model_q [$];
  logic [DW-1:0] sb_q [$];
  logic          ovf_m;
  logic          udf_m;
  logic          rd_m;

  // Packed reset image: data, valid, empty, ae, full, af, ovf, udf, count.
  localparam logic [19:0] RESET_IMG = {8'h00, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0};

  task automatic step(input logic we, input logic [DW-1:0] wd, input logic req,
                      input logic fl, input logic clr);
    logic rd, wr, ovf_ev, udf_ev;
    bus.write_enable      = we;
    bus.write_data        = wd;
    bus.fifo_request_data = req;
    bus.flush             = fl;
    bus.clear_flags       = clr;
    rd     = req && !fl && (model_q.size() != 0);
    wr     = we && !fl && ((model_q.size() < DEPTH) || rd);
    ovf_ev = we && !fl && !wr;
    udf_ev = req && !fl && (model_q.size() == 0);
    @(posedge clk);
    if (fl) begin
      model_q.delete();
    end else begin
      if (rd) sb_q.push_back(model_q.pop_front());
      if (wr) model_q.push_back(wd);
    end
    ovf_m = ovf_ev ? 1'b1 : (clr ? 1'b0 : ovf_m);
    udf_m = udf_ev ? 1'b1 : (clr ? 1'b0 : udf_m);
    rd_m  = rd;
    #1;
  endtask

  task automatic model_reset();
    model_q.delete();
    sb_q.delete();
    ovf_m = 1'b0;
    udf_m = 1'b0;
    rd_m  = 1'b0;
  endtask

  task automatic test_reset();
    logic [19:0] img;
    bus.write_enable = 1'b0; bus.write_data = '0; bus.fifo_request_data = 1'b0;
    bus.flush = 1'b0; bus.clear_flags = 1'b0;
    model_reset();
    #1 rst_n = 1'b0;
    #1;
    img = {bus.fifo_data, bus.fifo_data_valid, bus.fifo_empty, bus.fifo_almost_empty,
           bus.fifo_full, bus.fifo_almost_full, bus.fifo_overflow, bus.fifo_underflow, bus.fifo_count};
    checks++;
    if (img !== RESET_IMG) begin errors++; $display("FAIL reset_state: got %h expected %h", img, RESET_IMG); end
    @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;
  endtask

  task automatic test_fill_drain();
    logic [DW-1:0] exp_d;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, DW'(8'h10 + i), 1'b0, 1'b0, 1'b0);
      checks++;
      if (bus.fifo_count !== 4'(i + 1)) begin errors++; $display("FAIL fill_count: got %0d expected %0d", bus.fifo_count, i + 1); end
      checks++;
      if (bus.fifo_almost_full !== (i + 1 >= 6)) begin errors++; $display("FAIL fill_af: got %b at count %0d", bus.fifo_almost_full, i + 1); end
      checks++;
      if (bus.fifo_full !== (i + 1 == 8)) begin errors++; $display("FAIL fill_full: got %b at count %0d", bus.fifo_full, i + 1); end
    end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      checks++;
      if (bus.fifo_data_valid !== 1'b1) begin errors++; $display("FAIL drain_valid: got %b expected 1", bus.fifo_data_valid); end
      exp_d = sb_q.pop_front();
      checks++;
      if (bus.fifo_data !== exp_d) begin errors++; $display("FAIL drain_data: got %h expected %h", bus.fifo_data, exp_d); end
    end
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.fifo_data_valid !== 1'b0) begin errors++; $display("FAIL valid_pulse: got %b expected 0", bus.fifo_data_valid); end
    checks++;
    if (bus.fifo_empty !== 1'b1) begin errors++; $display("FAIL drain_empty: got %b expected 1", bus.fifo_empty); end
  endtask

  task automatic test_overflow();
    logic [DW-1:0] exp_d;
    for (int i = 0; i < 8; i++) step(1'b1, DW'(8'h20 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.fifo_overflow !== 1'b1) begin errors++; $display("FAIL ovf_set: got %b expected 1", bus.fifo_overflow); end
    checks++;
    if (bus.fifo_count !== 4'd8) begin errors++; $display("FAIL ovf_count: got %0d expected 8", bus.fifo_count); end
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.fifo_overflow !== 1'b1) begin errors++; $display("FAIL ovf_sticky: got %b expected 1", bus.fifo_overflow); end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      exp_d = sb_q.pop_front();
      checks++;
      if (bus.fifo_data !== exp_d || bus.fifo_data === 8'hAA) begin errors++; $display("FAIL ovf_drain: got %h expected %h", bus.fifo_data, exp_d); end
    end
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checks++;
    if (bus.fifo_overflow !== 1'b0) begin errors++; $display("FAIL ovf_clear: got %b expected 0", bus.fifo_overflow); end
  endtask

  task automatic test_full_rw();
    logic [DW-1:0] exp_d;
    for (int i = 0; i < 8; i++) step(1'b1, DW'(8'h30 + i), 1'b0, 1'b0, 1'b0);
    step(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    checks++;
    if (bus.fifo_count !== 4'd8) begin errors++; $display("FAIL full_rw_count: got %0d expected 8", bus.fifo_count); end
    exp_d = sb_q.pop_front();
    checks++;
    if (bus.fifo_data_valid !== 1'b1 || bus.fifo_data !== exp_d) begin errors++; $display("FAIL full_rw_head: got %h/%b expected %h/1", bus.fifo_data, bus.fifo_data_valid, exp_d); end
    checks++;
    if (bus.fifo_overflow !== 1'b0) begin errors++; $display("FAIL full_rw_ovf: got %b expected 0", bus.fifo_overflow); end
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      exp_d = sb_q.pop_front();
      checks++;
      if (bus.fifo_data !== exp_d) begin errors++; $display("FAIL full_rw_drain: got %h expected %h", bus.fifo_data, exp_d); end
    end
    checks++;
    if (bus.fifo_data !== 8'h55) begin errors++; $display("FAIL full_rw_last: got %h expected 55", bus.fifo_data); end
  endtask

  task automatic test_underflow();
    logic [DW-1:0] exp_d;
    step(1'b1, 8'h33, 1'b1, 1'b0, 1'b0);
    checks++;
    if (bus.fifo_underflow !== 1'b1) begin errors++; $display("FAIL udf_set: got %b expected 1", bus.fifo_underflow); end
    checks++;
    if (bus.fifo_data_valid !== 1'b0) begin errors++; $display("FAIL udf_valid: got %b expected 0", bus.fifo_data_valid); end
    checks++;
    if (bus.fifo_count !== 4'd1) begin errors++; $display("FAIL udf_count: got %0d expected 1", bus.fifo_count); end
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    exp_d = sb_q.pop_front();
    checks++;
    if (bus.fifo_data_valid !== 1'b1 || bus.fifo_data !== exp_d) begin errors++; $display("FAIL udf_read: got %h/%b expected %h/1", bus.fifo_data, bus.fifo_data_valid, exp_d); end
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checks++;
    if (bus.fifo_underflow !== 1'b0) begin errors++; $display("FAIL udf_clear: got %b expected 0", bus.fifo_underflow); end
  endtask

  task automatic test_wrap();
    logic [DW-1:0] exp_d;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, DW'(8'h40 + i), 1'b0, 1'b0, 1'b0);
      checks++;
      if (bus.fifo_almost_empty !== (i + 1 <= 2)) begin errors++; $display("FAIL wrap_ae_up: got %b at count %0d", bus.fifo_almost_empty, i + 1); end
    end
    for (int i = 0; i < 12; i++) begin
      step(1'b1, DW'(8'h50 + i), 1'b1, 1'b0, 1'b0);
      checks++;
      if (bus.fifo_count !== 4'd3) begin errors++; $display("FAIL wrap_count: got %0d expected 3", bus.fifo_count); end
      exp_d = sb_q.pop_front();
      checks++;
      if (bus.fifo_data_valid !== 1'b1 || bus.fifo_data !== exp_d) begin errors++; $display("FAIL wrap_data: got %h/%b expected %h/1", bus.fifo_data, bus.fifo_data_valid, exp_d); end
    end
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
      exp_d = sb_q.pop_front();
      checks++;
      if (bus.fifo_data !== exp_d) begin errors++; $display("FAIL wrap_tail: got %h expected %h", bus.fifo_data, exp_d); end
      checks++;
      if (bus.fifo_almost_empty !== 1'b1) begin errors++; $display("FAIL wrap_ae_down: got %b expected 1", bus.fifo_almost_empty); end
    end
  endtask

  task automatic test_flush();
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) step(1'b1, DW'(8'h60 + i), 1'b0, 1'b0, 1'b0);
    checks++;
    if (bus.fifo_count !== 4'd5) begin errors++; $display("FAIL flush_pre_count: got %0d expected 5", bus.fifo_count); end
    step(1'b1, 8'h77, 1'b1, 1'b1, 1'b0);
    checks++;
    if (bus.fifo_count !== 4'd0 || bus.fifo_empty !== 1'b1) begin errors++; $display("FAIL flush_count: got %0d/%b expected 0/1", bus.fifo_count, bus.fifo_empty); end
    checks++;
    if (bus.fifo_data_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b expected 0", bus.fifo_data_valid); end
    checks++;
    if (bus.fifo_underflow !== udf_m || bus.fifo_overflow !== ovf_m) begin errors++; $display("FAIL flush_flags: got %b%b expected %b%b", bus.fifo_overflow, bus.fifo_underflow, ovf_m, udf_m); end
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    checks++;
    if (bus.fifo_underflow !== 1'b0) begin errors++; $display("FAIL flush_clear: got %b expected 0", bus.fifo_underflow); end
  endtask

  task automatic test_async_reset();
    logic [19:0]   img;
    logic [DW-1:0] exp_d;
    for (int i = 0; i < 3; i++) step(1'b1, DW'(8'h70 + i), 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    bus.write_enable = 1'b1;
    bus.write_data   = 8'h99;
    bus.fifo_request_data = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    img = {bus.fifo_data, bus.fifo_data_valid, bus.fifo_empty, bus.fifo_almost_empty,
           bus.fifo_full, bus.fifo_almost_full, bus.fifo_overflow, bus.fifo_underflow, bus.fifo_count};
    checks++;
    if (img !== RESET_IMG) begin errors++; $display("FAIL async_reset: got %h expected %h", img, RESET_IMG); end
    @(posedge clk); #1;
    img = {bus.fifo_data, bus.fifo_data_valid, bus.fifo_empty, bus.fifo_almost_empty,
           bus.fifo_full, bus.fifo_almost_full, bus.fifo_overflow, bus.fifo_underflow, bus.fifo_count};
    checks++;
    if (img !== RESET_IMG) begin errors++; $display("FAIL reset_hold: got %h expected %h", img, RESET_IMG); end
    rst_n = 1'b1;
    step(1'b1, 8'hC3, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    exp_d = sb_q.pop_front();
    checks++;
    if (bus.fifo_data !== exp_d || bus.fifo_count !== 4'd0) begin errors++; $display("FAIL post_reset: got %h/%0d expected %h/0", bus.fifo_data, bus.fifo_count, exp_d); end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_fill_drain();
    test_overflow();
    test_full_rw();
    test_underflow();
    test_wrap();
    test_flush();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/data_fifo_param.md
Name: data_fifo_param

Overview:
Parametrised synchronous data FIFO and the next generation of the existing 8-bit data FIFO. Data width and depth are configurable. Adds programmable almost-full/almost-empty thresholds, an occupancy count, sticky overflow/underflow flags with a clear, and a synchronous flush. It sits between a producer and the consumer that drives fifo_request_data, and keeps the existing fifo_* signal semantics.

Parameters:
DATA_WIDTH, 8, width of write_data and fifo_data
DEPTH, 16, number of entries; power of two, >= 2
AF_LEVEL, DEPTH-2, fifo_almost_full asserts when count >= AF_LEVEL
AE_LEVEL, 2, fifo_almost_empty asserts when count <= AE_LEVEL

Ports:
clk  input  1  single clock; all logic on rising edge
rst_n  input  1  asynchronous, active-low reset
write_enable  input  1  push write_data this cycle
write_data  input  DATA_WIDTH  data to push
fifo_request_data  input  1  pop one entry this cycle
flush  input  1  synchronous empty of the FIFO contents
clear_flags  input  1  clears sticky fifo_overflow/fifo_underflow
fifo_data  output  DATA_WIDTH  registered read data
fifo_data_valid  output  1  fifo_data updated this cycle
fifo_empty  output  1  count == 0
fifo_full  output  1  count == DEPTH
fifo_almost_empty  output  1  count <= AE_LEVEL
fifo_almost_full  output  1  count >= AF_LEVEL
fifo_count  output  $clog2(DEPTH)+1  current occupancy, 0..DEPTH
fifo_overflow  output  1  sticky: a write was dropped
fifo_underflow  output  1  sticky: a read hit an empty FIFO

Behaviour:
- Reset (rst_n low, async): pointers=0; fifo_count=0; fifo_data=0; fifo_data_valid=0; fifo_overflow=0; fifo_underflow=0; fifo_empty=1; fifo_almost_empty=1; fifo_full=0; fifo_almost_full=0 (for AF_LEVEL>0). Storage contents are not reset.
- Status outputs are combinational decodes of the registered count. Each reflects the state after the previous edge.
- Pointers are log2(DEPTH) bits and wrap naturally from DEPTH-1 to 0.
- Read: fifo_request_data && !fifo_empty pops the head entry. The popped entry appears on fifo_data at the next edge with fifo_data_valid=1 for exactly one cycle (1-cycle latency). Otherwise fifo_data holds its last value and fifo_data_valid=0.
- Read on empty: no pop, fifo_data_valid=0, fifo_underflow set at the next edge. There is no fall-through: a same-cycle write to an empty FIFO is not readable that cycle.
- Write: write_enable && (!fifo_full || read accepted this cycle) stores write_data at the tail.
- Write while full with no read: data dropped, count unchanged, fifo_overflow set at the next edge.
- Simultaneous accepted read and write: count unchanged (including when full). Read returns the old head.
- Count update: +1 on write only, -1 on read only, unchanged otherwise.
- Flush: has priority over read and write in the same cycle. Pointers and count go to 0 and fifo_data_valid=0. fifo_data holds its value. Flags are unaffected, and a concurrent write/read sets no flag.
- clear_flags: clears both sticky flags at the next edge. If a new overflow/underflow event occurs in the same cycle, set wins.
- Reset mid-operation: all state returns to reset values immediately. No partial write is committed.
- Elaboration check: an error is raised if DEPTH is not a power of two, AF_LEVEL > DEPTH, or AE_LEVEL >= DEPTH.

Test Plan:
- DEPTH=8, DATA_WIDTH=8: write 0x10..0x17 over 8 cycles -> fifo_full=1, fifo_count=8, fifo_almost_full=1 from count 6. Then 8 reads -> fifo_data 0x10..0x17 each one cycle after its request, with fifo_data_valid pulses; fifo_empty=1 at the end.
- Full FIFO, write 0xAA with no read -> dropped, fifo_overflow=1 and sticky. Drain -> 0xAA never appears. Assert clear_flags -> fifo_overflow=0 next cycle.
- Full FIFO, simultaneous read and write of 0x55 -> count stays 8, read returns the old head. 0x55 emerges last after 8 further reads.
- Empty FIFO, fifo_request_data with write_enable of 0x33 -> fifo_underflow=1, fifo_data_valid=0, count=1. A next-cycle read returns 0x33.
- 12 write/read cycles with occupancy 3 (pointer wrap past 7) -> data order preserved. fifo_almost_empty toggles at count 2/3.
- Count=5, assert flush with write_enable -> count=0, fifo_empty=1, flags unchanged. Async rst_n pulse mid-burst -> all outputs at reset values within the same cycle.
